pa_ahbl_arb_if: RTL and testbench
=================================

# pa_ahbl_arb_if

Parametrised AHB-Lite master interface for the BIU. It arbitrates NUM_MST independent request ports onto one AHB-Lite bus. Each port follows the bmu request/grant/complete protocol. Arbitration is fixed-priority or round-robin, with overlapped address and data phases and full two-cycle ERROR handling. It replaces per-core single/dual-bus AHB-Lite interfaces and sits between the bmu and the pad-level AHB-Lite ports.

## Interface
Parameters:
- NUM_MST, 2: number of requesters, 1..8; index 0 is the highest fixed priority.
- AW, 32: address width.
- DW, 32: data width, 32 or 64. HSIZE up to log2(DW/8) is legal.
- ARB_MODE, 0: 0 = fixed priority, 1 = round-robin.

Ports:
- forever_cpuclk  in  1  clock. One clock; all state on its rising edge.
- cpurst_b  in  1  reset, asynchronous, active-low.
- mst_req  in  NUM_MST  per-port request. Held with its attributes stable until grant.
- mst_addr  in  NUM_MST*AW  per-port address.
- mst_write  in  NUM_MST  per-port write flag.
- mst_size  in  NUM_MST*3  per-port HSIZE.
- mst_prot  in  NUM_MST*4  per-port HPROT.
- mst_wdata  in  NUM_MST*DW  per-port write data, valid with req.
- mst_grnt  out  NUM_MST  one-hot grant pulse.
- mst_trans_cmplt  out  NUM_MST  one-hot data-phase completion pulse.
- mst_acc_err  out  NUM_MST  ERROR response. Qualified by trans_cmplt.
- mst_rdata  out  DW  shared read data. Valid with trans_cmplt.
- pad_hrdata  in  DW; pad_hready  in  1; pad_hresp  in  1.
- ahbl_pad_haddr  out  AW; ahbl_pad_htrans  out  2; ahbl_pad_hwrite  out  1; ahbl_pad_hsize  out  3; ahbl_pad_hprot  out  4; ahbl_pad_hburst  out  3 (always 3'b000 SINGLE); ahbl_pad_hwdata  out  DW.
- ahbl_idle  out  1  high when no request is pending and no data phase is outstanding.

## Operation
Address phase (combinational mux of the selected port):
- When no address is locked, the arbiter picks a requester: fixed priority takes the lowest index; round-robin takes the first set request at or after rr_ptr, wrapping.
- Selected port drives HTRANS=NONSEQ (2'b10) and its attributes. No selection gives HTRANS=IDLE (2'b00), with haddr/hwrite/hsize/hprot held at their last registered value.
- mst_grnt[i] = selected[i] & pad_hready.

Address lock:
- If NONSEQ is driven while pad_hready=0, the owner index is registered into addr_lock.
- While the lock is set, the same port stays selected regardless of new higher-priority requests.
- The lock clears in the cycle the grant is given.

Round-robin pointer:
- On grant, rr_ptr <= (granted_idx+1) mod NUM_MST. Reset value 0.
- In fixed mode rr_ptr is unused.

Data-phase register. On grant, capture:
- dp_vld<=1, dp_owner, dp_write
- dp_wdata <= mst_wdata of the owner

Without a new grant, dp_vld clears when pad_hready=1. ahbl_pad_hwdata = dp_wdata.

Completion:
- When dp_vld & pad_hready: mst_trans_cmplt[dp_owner]=1, and mst_acc_err[dp_owner]=pad_hresp.
- mst_rdata = pad_hrdata, passed through unconditionally.

ERROR handling:
- Error cycle 1 is dp_vld & pad_hresp & !pad_hready. Register err_cancel.
- Whenever pad_hresp=1 or err_cancel=1, force HTRANS=IDLE and suppress all grants. This cancels the next transfer; the request stays pending.
- err_cancel clears on the cycle with pad_hready=1.

ahbl_idle = !dp_vld & !(|mst_req).

## Timing
- Grant is in the same cycle as request when the bus is free and hready=1. Completion comes at the earliest one cycle after grant. Back-to-back transfers give one completion per cycle.
- Reset values: dp_vld=0, addr_lock clear, err_cancel=0, rr_ptr=0, dp_wdata=0, held address attributes=0.
- Outputs during reset: HTRANS=IDLE; grnt, trans_cmplt and acc_err are 0.
- Grant and completion in the same cycle for different or the same port: both pulses assert. The data-phase register reloads with the new owner.
- NUM_MST=1: arbitration degenerates to a wire, with identical timing.
- Requester drops req while locked: protocol violation, not checked; the address is still issued.
- Reset asserted mid-transfer: all state clears immediately, with no completion pulse.

## Structure
- Shared package pa_biu_pkg holds:
  - HTRANS_IDLE and HTRANS_NONSEQ encodings
  - HBURST_SINGLE
  - ARB_FIXED and ARB_RR constants
- Sub-module pa_ahbl_rr_arb(NUM_MST, ARB_MODE): request vector, pointer and lock in; one-hot grant and index out. Combinational except rr_ptr.
- Clock gating stays outside in the parent top.

## Test plan
- Single write, NUM_MST=2: req[0], addr 0x2000_0010, wdata 0xDEAD_BEEF, hready=1. Required: grnt[0] in cycle 0, HTRANS=2'b10; hwdata=0xDEAD_BEEF and trans_cmplt[0] in cycle 1.
- Fixed priority, both ports requesting continuously: grants go 0,0,0 with port 1 starved. Round-robin mode: grants go 0,1,0,1 and rr_ptr alternates.
- Wait states: hready=0 for 3 cycles after port 1 gets NONSEQ, with port 0 raising req meanwhile. Required: haddr stays on port 1 for all 3 cycles; port 1 is granted first.
- ERROR: data-phase cycle 1 with hresp=1, hready=0. Required: HTRANS=IDLE for both error cycles. Cycle 2 (hresp=1, hready=1): acc_err and trans_cmplt both pulse for the owner. The pending request is granted on the following cycle.
- Reset asserted while dp_vld=1 and hready=0. Required: no trans_cmplt; HTRANS=IDLE; ahbl_idle=1 when req=0.
- Back-to-back reads: 4 reads by port 0 with hready=1. Required: 4 consecutive completions with mst_rdata matching pad_hrdata each cycle.

Source files
------------

// File: rtl/pa_biu_pkg.sv
// Shared AHB-Lite encodings, arbitration modes and helpers for the BIU bus interfaces.
package pa_biu_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Address-phase attributes that are held on the bus while HTRANS is IDLE.
   typedef struct packed {
      logic       write;
      logic [2:0] size;
      logic [3:0] prot;
   } ahb_attr_t;

   // Requester index width; a single requester still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pa_ahbl_rr_arb.sv
// Requester selection for the AHB-Lite master: fixed priority or round-robin,
// overridden by a locked address owner. Only the round-robin pointer is state.
module pa_ahbl_rr_arb
   import pa_biu_pkg::*;
#(
   parameter int  NUM_MST  = 2,
   parameter int  ARB_MODE = ARB_FIXED,
   localparam int IW       = idx_w(NUM_MST)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_MST-1:0] req_i,
   input  logic               lock_vld_i,
   input  logic [IW-1:0]      lock_idx_i,
   input  logic               adv_i,
   output logic [NUM_MST-1:0] gnt_o,
   output logic [IW-1:0]      idx_o,
   output logic               vld_o
);

   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] pick_idx;
   logic          pick_vld;
   int            base_c;
   int            dist_c;
   int            best_c;

   // Smallest rotated distance from the search base wins; base is 0 in fixed mode.
   always_comb begin
      base_c   = (ARB_MODE == ARB_RR) ? int'(rr_ptr_q) : 0;
      best_c   = NUM_MST;
      dist_c   = 0;
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         dist_c = (i >= base_c) ? (i - base_c) : (i + NUM_MST - base_c);
         if (req_i[i] && (dist_c < best_c)) begin
            best_c   = dist_c;
            pick_vld = 1'b1;
            pick_idx = IW'(i);
         end
      end
   end

   assign vld_o = lock_vld_i | pick_vld;
   assign idx_o = lock_vld_i ? lock_idx_i : pick_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MST; gi++) begin : g_gnt
         assign gnt_o[gi] = vld_o & (idx_o == IW'(gi));
      end
   endgenerate

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (adv_i) begin
         rr_ptr_d = (idx_o == IW'(NUM_MST - 1)) ? '0 : idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/pa_ahbl_arb_if.sv
// AHB-Lite master interface for the BIU: arbitrates NUM_MST bmu request ports onto one
// bus with overlapped address/data phases and two-cycle ERROR cancellation.
module pa_ahbl_arb_if
   import pa_biu_pkg::*;
#(
   parameter int NUM_MST  = 2,
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int ARB_MODE = ARB_FIXED
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic [NUM_MST-1:0]    mst_req,
   input  logic [NUM_MST*AW-1:0] mst_addr,
   input  logic [NUM_MST-1:0]    mst_write,
   input  logic [NUM_MST*3-1:0]  mst_size,
   input  logic [NUM_MST*4-1:0]  mst_prot,
   input  logic [NUM_MST*DW-1:0] mst_wdata,
   output logic [NUM_MST-1:0]    mst_grnt,
   output logic [NUM_MST-1:0]    mst_trans_cmplt,
   output logic [NUM_MST-1:0]    mst_acc_err,
   output logic [DW-1:0]         mst_rdata,
   input  logic [DW-1:0]         pad_hrdata,
   input  logic                  pad_hready,
   input  logic                  pad_hresp,
   output logic [AW-1:0]         ahbl_pad_haddr,
   output logic [1:0]            ahbl_pad_htrans,
   output logic                  ahbl_pad_hwrite,
   output logic [2:0]            ahbl_pad_hsize,
   output logic [3:0]            ahbl_pad_hprot,
   output logic [2:0]            ahbl_pad_hburst,
   output logic [DW-1:0]         ahbl_pad_hwdata,
   output logic                  ahbl_idle
);

   localparam int IW = idx_w(NUM_MST);

   logic [NUM_MST-1:0] sel_oh;
   logic [IW-1:0]      sel_idx;
   logic               sel_vld;
   logic [AW-1:0]      sel_addr;
   logic [DW-1:0]      sel_wdata;
   ahb_attr_t          sel_attr;

   logic               cancel, drive, grant, cmplt;
   logic [NUM_MST-1:0] owner_oh;

   logic               lock_vld_q, lock_vld_d;
   logic [IW-1:0]      lock_idx_q, lock_idx_d;
   logic               dp_vld_q, dp_vld_d;
   logic [IW-1:0]      dp_owner_q, dp_owner_d;
   logic [DW-1:0]      dp_wdata_q, dp_wdata_d;
   logic               err_cancel_q, err_cancel_d;
   logic [AW-1:0]      haddr_q, haddr_d;
   ahb_attr_t          attr_q, attr_d;

   pa_ahbl_rr_arb #(
      .NUM_MST  (NUM_MST),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .clk        (forever_cpuclk),
      .rst_n      (cpurst_b),
      .req_i      (mst_req),
      .lock_vld_i (lock_vld_q),
      .lock_idx_i (lock_idx_q),
      .adv_i      (grant),
      .gnt_o      (sel_oh),
      .idx_o      (sel_idx),
      .vld_o      (sel_vld)
   );

   assign sel_addr       = mst_addr[int'(sel_idx)*AW +: AW];
   assign sel_wdata      = mst_wdata[int'(sel_idx)*DW +: DW];
   assign sel_attr.write = mst_write[sel_idx];
   assign sel_attr.size  = mst_size[int'(sel_idx)*3 +: 3];
   assign sel_attr.prot  = mst_prot[int'(sel_idx)*4 +: 4];

   // Any HRESP=1 cycle, and the cycle after error cycle 1, withdraws the pending address.
   assign cancel = pad_hresp | err_cancel_q;
   assign drive  = sel_vld & ~cancel & cpurst_b;
   assign grant  = drive & pad_hready;
   assign cmplt  = dp_vld_q & pad_hready;

   assign ahbl_pad_htrans = drive ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign ahbl_pad_haddr  = drive ? sel_addr : haddr_q;
   assign {ahbl_pad_hwrite, ahbl_pad_hsize, ahbl_pad_hprot} = drive ? sel_attr : attr_q;
   assign ahbl_pad_hburst = HBURST_SINGLE;
   assign ahbl_pad_hwdata = dp_wdata_q;
   assign mst_rdata       = pad_hrdata;
   assign mst_grnt        = sel_oh & {NUM_MST{grant}};
   assign ahbl_idle       = ~dp_vld_q & ~(|mst_req);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MST; gi++) begin : g_cmplt
         assign owner_oh[gi]        = (dp_owner_q == IW'(gi));
         assign mst_trans_cmplt[gi] = cmplt & owner_oh[gi];
         assign mst_acc_err[gi]     = cmplt & owner_oh[gi] & pad_hresp;
      end
   endgenerate

   always_comb begin
      lock_vld_d   = lock_vld_q;
      lock_idx_d   = lock_idx_q;
      dp_vld_d     = dp_vld_q;
      dp_owner_d   = dp_owner_q;
      dp_wdata_d   = dp_wdata_q;
      err_cancel_d = err_cancel_q;
      haddr_d      = haddr_q;
      attr_d       = attr_q;

      if (grant) begin
         lock_vld_d = 1'b0;
      end else if (drive && !pad_hready) begin
         lock_vld_d = 1'b1;
         lock_idx_d = sel_idx;
      end

      if (grant) begin
         dp_vld_d   = 1'b1;
         dp_owner_d = sel_idx;
         dp_wdata_d = sel_wdata;
      end else if (pad_hready) begin
         dp_vld_d = 1'b0;
      end

      if (pad_hready) begin
         err_cancel_d = 1'b0;
      end else if (dp_vld_q && pad_hresp) begin
         err_cancel_d = 1'b1;
      end

      if (drive) begin
         haddr_d = sel_addr;
         attr_d  = sel_attr;
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         lock_vld_q   <= 1'b0;
         lock_idx_q   <= '0;
         dp_vld_q     <= 1'b0;
         dp_owner_q   <= '0;
         dp_wdata_q   <= '0;
         err_cancel_q <= 1'b0;
         haddr_q      <= '0;
         attr_q       <= '0;
      end else begin
         lock_vld_q   <= lock_vld_d;
         lock_idx_q   <= lock_idx_d;
         dp_vld_q     <= dp_vld_d;
         dp_owner_q   <= dp_owner_d;
         dp_wdata_q   <= dp_wdata_d;
         err_cancel_q <= err_cancel_d;
         haddr_q      <= haddr_d;
         attr_q       <= attr_d;
      end
   end

endmodule

// File: tb/tb_pa_ahbl_arb_if.sv
// Directed bench for pa_ahbl_arb_if: a fixed-priority and a round-robin instance share stimulus;
// completions of the fixed instance are checked against a scoreboard filled at grant time.
module tb_pa_ahbl_arb_if;
   import pa_biu_pkg::*;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [N-1:0]    req, wr;
   logic [N*AW-1:0] addr;
   logic [N*3-1:0]  size;
   logic [N*4-1:0]  prot;
   logic [N*DW-1:0] wdata;
   logic [DW-1:0]   hrdata;
   logic            hready, hresp;

   logic [N-1:0]  grnt, cmplt, acc_err;
   logic [DW-1:0] rdata, hwdata;
   logic [AW-1:0] haddr;
   logic [1:0]    htrans;
   logic          hwrite, idle;
   logic [2:0]    hsize, hburst;
   logic [3:0]    hprot;

   logic [N-1:0]  grnt_r, cmplt_r, acc_err_r;
   logic [DW-1:0] rdata_r, hwdata_r;
   logic [AW-1:0] haddr_r;
   logic [1:0]    htrans_r;
   logic          hwrite_r, idle_r;
   logic [2:0]    hsize_r, hburst_r;
   logic [3:0]    hprot_r;

   pa_ahbl_arb_if #(.NUM_MST(N), .AW(AW), .DW(DW), .ARB_MODE(ARB_FIXED)) dut (
      .forever_cpuclk (clk),     .cpurst_b (rst_n),
      .mst_req (req), .mst_addr (addr), .mst_write (wr), .mst_size (size),
      .mst_prot (prot), .mst_wdata (wdata),
      .mst_grnt (grnt), .mst_trans_cmplt (cmplt), .mst_acc_err (acc_err), .mst_rdata (rdata),
      .pad_hrdata (hrdata), .pad_hready (hready), .pad_hresp (hresp),
      .ahbl_pad_haddr (haddr), .ahbl_pad_htrans (htrans), .ahbl_pad_hwrite (hwrite),
      .ahbl_pad_hsize (hsize), .ahbl_pad_hprot (hprot), .ahbl_pad_hburst (hburst),
      .ahbl_pad_hwdata (hwdata), .ahbl_idle (idle)
   );

   pa_ahbl_arb_if #(.NUM_MST(N), .AW(AW), .DW(DW), .ARB_MODE(ARB_RR)) dut_rr (
      .forever_cpuclk (clk),     .cpurst_b (rst_n),
      .mst_req (req), .mst_addr (addr), .mst_write (wr), .mst_size (size),
      .mst_prot (prot), .mst_wdata (wdata),
      .mst_grnt (grnt_r), .mst_trans_cmplt (cmplt_r), .mst_acc_err (acc_err_r), .mst_rdata (rdata_r),
      .pad_hrdata (hrdata), .pad_hready (hready), .pad_hresp (hresp),
      .ahbl_pad_haddr (haddr_r), .ahbl_pad_htrans (htrans_r), .ahbl_pad_hwrite (hwrite_r),
      .ahbl_pad_hsize (hsize_r), .ahbl_pad_hprot (hprot_r), .ahbl_pad_hburst (hburst_r),
      .ahbl_pad_hwdata (hwdata_r), .ahbl_idle (idle_r)
   );

   typedef struct {
      int          owner;
      logic        err;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk   = 0;
   int   n_pass  = 0;
   int   cyc_n   = 0;
   logic plan_err;
   logic push_en;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One line per transaction: grants push expectations, completions pop and compare.
   task automatic sample(input logic [1:0] eg, input logic [1:0] et, input int erg);
      exp_t       e;
      logic [1:0] oh;
      @(negedge clk);
      chk("grnt", {62'd0, grnt}, {62'd0, eg});
      chk("htrans", {62'd0, htrans}, {62'd0, et});
      if (erg >= 0) chk("rr_grnt", {62'd0, grnt_r}, {62'd0, erg[1:0]});
      if (eg != 2'b00 && push_en) begin
         e.owner = eg[1] ? 1 : 0;
         e.err   = plan_err;
         e.wr    = wr[e.owner];
         e.wdata = wdata[e.owner*DW +: DW];
         e.rdata = 32'hC0DE_0000 + cyc_n + 1;
         sb_q.push_back(e);
         $display("t=%0t grant port%0d addr=%08h write=%0b", $time, e.owner, haddr, e.wr);
      end
      if (cmplt != 2'b00) begin
         if (sb_q.size() == 0) begin
            chk("sb_extra_cmplt", {62'd0, cmplt}, 64'd0);
         end else begin
            e  = sb_q.pop_front();
            oh = 2'b01 << e.owner;
            chk("sb_owner", {62'd0, cmplt}, {62'd0, oh});
            chk("sb_acc_err", {62'd0, acc_err}, {62'd0, (e.err ? oh : 2'b00)});
            if (e.wr) chk("sb_hwdata", {32'd0, hwdata}, {32'd0, e.wdata});
            else      chk("sb_rdata", {32'd0, rdata}, {32'd0, e.rdata});
            $display("t=%0t cmplt port%0d err=%0b rdata=%08h hwdata=%08h", $time, e.owner, acc_err != 0, rdata, hwdata);
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      cyc_n++;
      hrdata = 32'hC0DE_0000 + cyc_n;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      req    = '0;
      hready = 1'b1;
      hresp  = 1'b0;
      adv();
      adv();
      rst_n  = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      req      = '0;
      wr       = '0;
      addr     = '0;
      size     = '0;
      prot     = '0;
      wdata    = '0;
      hrdata   = 32'hC0DE_0000;
      hready   = 1'b1;
      hresp    = 1'b0;
      plan_err = 1'b0;
      push_en  = 1'b1;

      // Reset values
      @(negedge clk);
      chk("rst_htrans", {62'd0, htrans}, {62'd0, HTRANS_IDLE});
      chk("rst_grnt", {62'd0, grnt}, 64'd0);
      chk("rst_cmplt", {62'd0, cmplt}, 64'd0);
      chk("rst_acc_err", {62'd0, acc_err}, 64'd0);
      chk("rst_idle", {63'd0, idle}, 64'd1);
      chk("rst_haddr", {32'd0, haddr}, 64'd0);
      chk("rst_hwdata", {32'd0, hwdata}, 64'd0);
      chk("rst_hburst", {61'd0, hburst}, {61'd0, HBURST_SINGLE});
      adv();
      rst_n = 1'b1;

      // Single write by port 0
      req          = 2'b01;
      wr           = 2'b11;
      addr[31:0]   = 32'h2000_0010;
      size[2:0]    = 3'b010;
      prot[3:0]    = 4'b0011;
      wdata[31:0]  = 32'hDEAD_BEEF;
      sample(2'b01, HTRANS_NONSEQ, -1);
      chk("t1_haddr", {32'd0, haddr}, 64'h2000_0010);
      chk("t1_hsize", {61'd0, hsize}, 64'd2);
      chk("t1_hprot", {60'd0, hprot}, 64'd3);
      chk("t1_hwrite", {63'd0, hwrite}, 64'd1);
      adv();
      req = 2'b00;
      sample(2'b00, HTRANS_IDLE, -1);
      chk("t1_cmplt", {62'd0, cmplt}, 64'd1);
      chk("t1_hwdata", {32'd0, hwdata}, 64'hDEAD_BEEF);
      chk("t1_haddr_hold", {32'd0, haddr}, 64'h2000_0010);
      adv();

      // Both ports requesting: fixed starves port 1, round-robin alternates
      do_reset();
      addr  = {32'h3000_0000, 32'h2000_0020};
      wdata = {32'h1111_2222, 32'h3333_4444};
      req   = 2'b11;
      for (int k = 0; k < 4; k++) begin
         sample(2'b01, HTRANS_NONSEQ, (k % 2 == 0) ? 1 : 2);
         chk("t2_haddr", {32'd0, haddr}, 64'h2000_0020);
         adv();
      end
      req = 2'b00;
      sample(2'b00, HTRANS_IDLE, -1);
      adv();

      // Wait states: port 1 holds the address while port 0 arrives
      addr[63:32] = 32'h3000_0040;
      req         = 2'b10;
      hready      = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) req = 2'b11;
         sample(2'b00, HTRANS_NONSEQ, -1);
         chk("t3_haddr_wait", {32'd0, haddr}, 64'h3000_0040);
         adv();
      end
      hready = 1'b1;
      sample(2'b10, HTRANS_NONSEQ, -1);
      chk("t3_haddr_gnt", {32'd0, haddr}, 64'h3000_0040);
      adv();
      req = 2'b01;
      sample(2'b01, HTRANS_NONSEQ, -1);
      chk("t3_haddr_p0", {32'd0, haddr}, 64'h2000_0020);
      adv();
      req = 2'b00;
      sample(2'b00, HTRANS_IDLE, -1);
      adv();

      // Two-cycle ERROR response on a port 0 write, port 1 pending
      plan_err   = 1'b1;
      req        = 2'b01;
      addr[31:0] = 32'h2000_0080;
      sample(2'b01, HTRANS_NONSEQ, -1);
      adv();
      plan_err = 1'b0;
      req      = 2'b10;
      hresp    = 1'b1;
      hready   = 1'b0;
      sample(2'b00, HTRANS_IDLE, -1);
      chk("t4_cmplt_c1", {62'd0, cmplt}, 64'd0);
      adv();
      hready = 1'b1;
      sample(2'b00, HTRANS_IDLE, -1);
      chk("t4_cmplt_c2", {62'd0, cmplt}, 64'd1);
      chk("t4_err_c2", {62'd0, acc_err}, 64'd1);
      adv();
      hresp = 1'b0;
      sample(2'b10, HTRANS_NONSEQ, -1);
      chk("t4_haddr_p1", {32'd0, haddr}, 64'h3000_0040);
      adv();
      req = 2'b00;
      sample(2'b00, HTRANS_IDLE, -1);
      adv();

      // Reset asserted during a stalled data phase
      push_en = 1'b0;
      req     = 2'b01;
      sample(2'b01, HTRANS_NONSEQ, -1);
      adv();
      req    = 2'b00;
      hready = 1'b0;
      sample(2'b00, HTRANS_IDLE, -1);
      chk("t5_pre_cmplt", {62'd0, cmplt}, 64'd0);
      chk("t5_busy", {63'd0, idle}, 64'd0);
      #2;
      rst_n  = 1'b0;
      hready = 1'b1;
      #1;
      chk("t5_cmplt", {62'd0, cmplt}, 64'd0);
      chk("t5_htrans", {62'd0, htrans}, {62'd0, HTRANS_IDLE});
      chk("t5_idle", {63'd0, idle}, 64'd1);
      req = 2'b01;
      #1;
      chk("t5_htrans_req", {62'd0, htrans}, {62'd0, HTRANS_IDLE});
      chk("t5_grnt", {62'd0, grnt}, 64'd0);
      adv();
      adv();
      req     = 2'b00;
      rst_n   = 1'b1;
      push_en = 1'b1;

      // Back-to-back reads by port 0
      wr  = 2'b00;
      req = 2'b01;
      for (int k = 0; k < 4; k++) begin
         addr[31:0] = 32'h2000_1000 + k * 4;
         sample(2'b01, HTRANS_NONSEQ, -1);
         chk("t6_haddr", {32'd0, haddr}, {32'd0, 32'h2000_1000 + k * 4});
         adv();
      end
      req = 2'b00;
      sample(2'b00, HTRANS_IDLE, -1);
      chk("t6_last_cmplt", {62'd0, cmplt}, 64'd1);
      adv();

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      chk("final_idle", {63'd0, idle}, 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
